// File: rtl/demux_lane_scheduler_if.sv
// Handshake bundle for the nibble lane demux scheduler.
//   up_data/up_valid/up_ready : upstream 4-bit symbol handshake
//   flush                     : release a partially filled word (pulse)
//   sel                       : lane select to the demux (lane being filled)
//   word_data/lane_mask       : assembled lane word, lane 0 in the MSBs
//   word_valid/word_ready     : downstream word handshake
//   word_cnt                  : words delivered, wrapping
interface demux_lane_scheduler_if #(
  parameter int unsigned NB_LANES = 2,
  parameter int unsigned FCNT_W   = 8
);
  logic [3:0]            up_data;
  logic                  up_valid;
  logic                  up_ready;
  logic                  flush;
  logic [1:0]            sel;
  logic [4*NB_LANES-1:0] word_data;
  logic [NB_LANES-1:0]   lane_mask;
  logic                  word_valid;
  logic                  word_ready;
  logic [FCNT_W-1:0]     word_cnt;

  modport master (
    output up_data, up_valid, flush, word_ready,
    input  up_ready, sel, word_data, lane_mask, word_valid, word_cnt
  );

  modport slave (
    input  up_data, up_valid, flush, word_ready,
    output up_ready, sel, word_data, lane_mask, word_valid, word_cnt
  );
endinterface

// File: rtl/demux_lane_scheduler.sv
// Sequencer for the nibble 1:N lane demultiplexer.
// Collects one 4-bit symbol per lane round-robin, then holds the full
// (or flushed partial) word until downstream takes it.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of demux_lane_scheduler_if (symbol in, word out)
module demux_lane_scheduler #(
  parameter int unsigned NB_LANES = 2,
  parameter int unsigned FCNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_lane_scheduler_if.slave bus
);

  localparam int unsigned DATA_W   = 4 * NB_LANES;
  localparam logic [1:0]  LAST_SEL = 2'(NB_LANES - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state, state_nx;
  logic                ready_q, ready_nx;
  logic                valid_q, valid_nx;
  logic [1:0]          sel_q, sel_nx;
  logic [DATA_W-1:0]   data_q, data_nx;
  logic [NB_LANES-1:0] mask_q, mask_nx;
  logic [FCNT_W-1:0]   cnt_q, cnt_nx;
  logic                accept_c;

  // ready_q is only ever high in FILL, so it alone qualifies a transfer
  assign accept_c = bus.up_valid && ready_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= 2'd0;
      data_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      ready_q <= ready_nx;
      valid_q <= valid_nx;
      sel_q   <= sel_nx;
      data_q  <= data_nx;
      mask_q  <= mask_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    sel_nx   = sel_q;
    data_nx  = data_q;
    mask_nx  = mask_q;
    cnt_nx   = cnt_q;

    case (state)
      FILL: begin
        if (accept_c) begin
          for (int i = 0; i < int'(NB_LANES); i++) begin
            if (sel_q == 2'(i)) begin
              data_nx[4*(int'(NB_LANES)-1-i) +: 4] = bus.up_data;
              mask_nx[int'(NB_LANES)-1-i]          = 1'b1;
            end
          end
          if (sel_q == LAST_SEL) begin
            sel_nx   = 2'd0;
            state_nx = HOLD;
          end else begin
            sel_nx = sel_q + 2'd1;
          end
        end
        // A symbol taken this cycle counts as a filled lane for flush
        if (bus.flush && ((mask_q != '0) || accept_c)) begin
          sel_nx   = 2'd0;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (bus.word_ready) begin
          data_nx  = '0;
          mask_nx  = '0;
          cnt_nx   = cnt_q + FCNT_W'(1);
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase

    // Handshake flags are registered copies of the next state
    ready_nx = (state_nx == FILL);
    valid_nx = (state_nx == HOLD);
  end

  assign bus.up_ready   = ready_q;
  assign bus.word_valid = valid_q;
  assign bus.sel        = sel_q;
  assign bus.word_data  = data_q;
  assign bus.lane_mask  = mask_q;
  assign bus.word_cnt   = cnt_q;

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Bench for demux_lane_scheduler: a 2-lane instance checked through a word
// scoreboard plus directed checks, and a 4-lane instance for select order.
module tb_demux_lane_scheduler;

  logic clk;
  logic rst;

  demux_lane_scheduler_if #(.NB_LANES(2), .FCNT_W(8)) bus2 ();
  demux_lane_scheduler_if #(.NB_LANES(4), .FCNT_W(8)) bus4 ();

  demux_lane_scheduler #(.NB_LANES(2), .FCNT_W(8)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  demux_lane_scheduler #(.NB_LANES(4), .FCNT_W(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] mask;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pushed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] m);
    exp_t e;
    e.data = d;
    e.mask = m;
    q.push_back(e);
    n_pushed++;
  endtask

  // Present one symbol on the 2-lane bus and hold it until it is taken
  task automatic send_sym(input logic [3:0] s, input logic fl);
    int t;
    t = 0;
    bus2.up_data  = s;
    bus2.up_valid = 1'b1;
    bus2.flush    = fl;
    @(negedge clk);
    while (!bus2.up_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus2.up_valid = 1'b0;
    bus2.flush    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares delivered words and protocol stability
  logic       pv, pr, cnt_chk;
  logic [7:0] pd, exp_cnt;
  logic [1:0] pm;
  exp_t       e_mon;

  always @(negedge clk) begin
    if (rst) begin
      pv      = 1'b0;
      pr      = 1'b0;
      cnt_chk = 1'b0;
      exp_cnt = 8'd0;
    end else begin
      if (cnt_chk) begin
        check("word_cnt", 32'(bus2.word_cnt), 32'(exp_cnt));
        check("no_bypass", 32'(bus2.word_valid), 32'd0);
        cnt_chk = 1'b0;
      end
      if (pv && !pr) begin
        check("valid_hold", 32'(bus2.word_valid), 32'd1);
        check("data_stable", 32'(bus2.word_data), 32'(pd));
        check("mask_stable", 32'(bus2.lane_mask), 32'(pm));
      end
      if (bus2.word_valid && bus2.word_ready) begin
        if (q.size() == 0) begin
          check("unexpected_word", 32'd1, 32'd0);
        end else begin
          e_mon = q.pop_front();
          check("word_data", 32'(bus2.word_data), 32'(e_mon.data));
          check("word_mask", 32'(bus2.lane_mask), 32'(e_mon.mask));
        end
        exp_cnt = exp_cnt + 8'd1;
        cnt_chk = 1'b1;
      end
      pv = bus2.word_valid;
      pr = bus2.word_ready;
      pd = bus2.word_data;
      pm = bus2.lane_mask;
    end
  end

  initial begin
    logic [3:0] s0, s1;
    rst             = 1'b1;
    bus2.up_data    = 4'd0;
    bus2.up_valid   = 1'b0;
    bus2.flush      = 1'b0;
    bus2.word_ready = 1'b0;
    bus4.up_data    = 4'd0;
    bus4.up_valid   = 1'b0;
    bus4.flush      = 1'b0;
    bus4.word_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus2.word_valid), 32'd0);
    check("rst_data", 32'(bus2.word_data), 32'd0);
    check("rst_mask", 32'(bus2.lane_mask), 32'd0);
    check("rst_sel", 32'(bus2.sel), 32'd0);
    check("rst_cnt", 32'(bus2.word_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("ready_after_rst", 32'(bus2.up_ready), 32'd1);

    // T1: asynchronous reset after one symbol
    send_sym(4'h1, 1'b0);
    check("t1_sel1", 32'(bus2.sel), 32'd1);
    check("t1_mask1", 32'(bus2.lane_mask), 32'h2);
    #2 rst = 1'b1;
    #1;
    check("t1_async_sel", 32'(bus2.sel), 32'd0);
    check("t1_async_mask", 32'(bus2.lane_mask), 32'd0);
    check("t1_async_data", 32'(bus2.word_data), 32'd0);
    check("t1_async_valid", 32'(bus2.word_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("t1_ready", 32'(bus2.up_ready), 32'd1);

    // T2: back-to-back full word with downstream ready
    bus2.word_ready = 1'b1;
    push(8'hA5, 2'b11);
    send_sym(4'hA, 1'b0);
    send_sym(4'h5, 1'b0);
    check("t2_latency", 32'(bus2.word_valid), 32'd1);
    check("t2_ready_low", 32'(bus2.up_ready), 32'd0);
    check("t2_data", 32'(bus2.word_data), 32'hA5);
    step();
    check("t2_one_cycle", 32'(bus2.word_valid), 32'd0);
    check("t2_cnt", 32'(bus2.word_cnt), 32'd1);
    check("t2_ready_back", 32'(bus2.up_ready), 32'd1);

    // T3: backpressure, waiting symbol must not be taken
    bus2.word_ready = 1'b0;
    push(8'h12, 2'b11);
    send_sym(4'h1, 1'b0);
    send_sym(4'h2, 1'b0);
    bus2.up_data  = 4'h3;
    bus2.up_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_ready_low", 32'(bus2.up_ready), 32'd0);
      check("t3_data_held", 32'(bus2.word_data), 32'h12);
      check("t3_sel_held", 32'(bus2.sel), 32'd0);
      step();
    end
    bus2.word_ready = 1'b1;
    step();
    check("t3_released", 32'(bus2.word_valid), 32'd0);
    check("t3_not_taken", 32'(bus2.sel), 32'd0);
    push(8'h34, 2'b11);
    send_sym(4'h3, 1'b0);
    check("t3_taken", 32'(bus2.sel), 32'd1);
    send_sym(4'h4, 1'b0);
    step();

    // T4: flush of a partial word, then flush on an empty word
    push(8'hC0, 2'b10);
    send_sym(4'hC, 1'b0);
    bus2.flush = 1'b1;
    step();
    bus2.flush = 1'b0;
    check("t4_valid", 32'(bus2.word_valid), 32'd1);
    check("t4_mask", 32'(bus2.lane_mask), 32'h2);
    check("t4_sel", 32'(bus2.sel), 32'd0);
    step();
    bus2.flush = 1'b1;
    step();
    bus2.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t4_empty_flush", 32'(bus2.word_valid), 32'd0);
      check("t4_empty_ready", 32'(bus2.up_ready), 32'd1);
      step();
    end

    // T5: symbol and flush in the same cycle
    push(8'h70, 2'b10);
    send_sym(4'h7, 1'b1);
    check("t5_valid", 32'(bus2.word_valid), 32'd1);
    check("t5_data", 32'(bus2.word_data), 32'h70);
    check("t5_mask", 32'(bus2.lane_mask), 32'h2);
    check("t5_sel", 32'(bus2.sel), 32'd0);
    step();

    // Flush while a full word is held is ignored
    bus2.word_ready = 1'b0;
    push(8'h9B, 2'b11);
    send_sym(4'h9, 1'b0);
    send_sym(4'hB, 1'b0);
    bus2.flush = 1'b1;
    step();
    bus2.flush = 1'b0;
    check("hold_flush_valid", 32'(bus2.word_valid), 32'd1);
    check("hold_flush_data", 32'(bus2.word_data), 32'h9B);
    bus2.word_ready = 1'b1;
    step();

    // T6: run the delivered-word counter through its wrap
    while (n_pushed < 256) begin
      s0 = 4'($urandom);
      s1 = 4'($urandom);
      push({s0, s1}, 2'b11);
      send_sym(s0, 1'b0);
      send_sym(s1, 1'b0);
    end
    for (int t = 0; t < 20 && q.size() != 0; t++) step();
    check("drain", 32'(q.size()), 32'd0);
    step();
    check("t6_cnt_wrap", 32'(bus2.word_cnt), 32'd0);

    // T6: four-lane select order and flush of two lanes
    for (int i = 0; i < 4; i++) begin
      check("t6_sel4", 32'(bus4.sel), 32'(i));
      check("t6_ready4", 32'(bus4.up_ready), 32'd1);
      bus4.up_data  = 4'(i + 1);
      bus4.up_valid = 1'b1;
      step();
    end
    bus4.up_valid = 1'b0;
    check("t6_sel4_wrap", 32'(bus4.sel), 32'd0);
    check("t6_valid4", 32'(bus4.word_valid), 32'd1);
    check("t6_data4", 32'(bus4.word_data), 32'h1234);
    check("t6_mask4", 32'(bus4.lane_mask), 32'hF);
    step();
    check("t6_cnt4", 32'(bus4.word_cnt), 32'd1);
    bus4.up_data  = 4'h5;
    bus4.up_valid = 1'b1;
    step();
    bus4.up_data = 4'h6;
    bus4.flush   = 1'b1;
    step();
    bus4.up_valid = 1'b0;
    bus4.flush    = 1'b0;
    check("t6_flush4_data", 32'(bus4.word_data), 32'h5600);
    check("t6_flush4_mask", 32'(bus4.lane_mask), 32'hC);
    check("t6_flush4_sel", 32'(bus4.sel), 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
